wbm_spi_rx_sync: RTL

- Wishbone-clock-domain end of the SPI receive handshake. It runs the 4-phase request/acknowledge exchange with the SCK-domain receiver through handshake_wb and handshake_spi, and captures each received byte.
- Captured bytes are buffered in a small FIFO and presented as a valid/ready byte stream to the Wishbone master logic.
- Sits between the SPI receiver and the command decoder of the SPI-to-Wishbone bridge.

---
 rtl/wbm_spi_pkg.sv | 5 +
 rtl/wbm_spi_fifo.sv | 42 ++++
 rtl/wbm_spi_rx_sync.sv | 63 ++++++
 3 files changed

// File: rtl/wbm_spi_pkg.sv
// wbm_spi_pkg: shared FSM states and byte width for the SPI-to-Wishbone bridge.
package wbm_spi_pkg;
    typedef enum logic [1:0] {IDLE, REQ, WAIT_DOWN} state_t;
    localparam int BYTE_W = 8;
endpackage

// File: rtl/wbm_spi_fifo.sv
// wbm_spi_fifo: single-clock FIFO with occupancy count; head byte reads as zero when empty.
module wbm_spi_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_push,
    input  logic [WIDTH-1:0]      i_din,
    input  logic                  i_pop,
    output logic [WIDTH-1:0]      o_dout,
    output logic                  o_valid,
    output logic                  o_full,
    output logic [DEPTH_LOG2:0]   o_level
);
    logic [WIDTH-1:0]      r_mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] r_wr, r_rd;
    logic [DEPTH_LOG2:0]   r_level;
    logic                  w_push, w_pop;

    assign o_valid = |r_level;
    assign o_full  = r_level[DEPTH_LOG2];
    assign o_level = r_level;
    assign o_dout  = o_valid ? r_mem[r_rd] : '0;
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && o_valid;

    always_ff @(posedge i_clk)
        if (w_push) r_mem[r_wr] <= i_din;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_level <= r_level + {{DEPTH_LOG2{1'b0}}, w_push} - {{DEPTH_LOG2{1'b0}}, w_pop};
        end
    end
endmodule

// File: rtl/wbm_spi_rx_sync.sv
// wbm_spi_rx_sync: Wishbone-side 4-phase handshake with the SCK-domain receiver,
// buffering received bytes into a FIFO presented as a valid/ready stream.
module wbm_spi_rx_sync
    import wbm_spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEPTH_LOG2  = 2
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_ni,
    input  logic                 handshake_spi,
    input  logic [BYTE_W-1:0]    handshake_data,
    output logic                 handshake_wb,
    output logic                 rx_valid,
    output logic [BYTE_W-1:0]    rx_data,
    input  logic                 rx_ready,
    output logic [DEPTH_LOG2:0]  rx_level
);
    logic [SYNC_STAGES-1:0] r_sync, r_fill;
    state_t                 r_state;
    logic                   w_spi_s, w_primed, w_push, w_full;

    assign w_spi_s  = r_sync[SYNC_STAGES-1];
    assign w_primed = r_fill[SYNC_STAGES-1];
    assign w_push   = (r_state == REQ) && w_spi_s;

    // r_fill marks when the synchronizer holds real pin samples rather than reset zeros,
    // so a handshake_spi held high across reset is not mistaken for a released line.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_sync       <= '0;
            r_fill       <= '0;
            r_state      <= WAIT_DOWN;
            handshake_wb <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], handshake_spi};
            r_fill <= {r_fill[SYNC_STAGES-2:0], 1'b1};
            case (r_state)
                IDLE: if (!w_full) begin
                    handshake_wb <= 1'b1;
                    r_state      <= REQ;
                end
                REQ: if (w_spi_s) begin
                    handshake_wb <= 1'b0;
                    r_state      <= WAIT_DOWN;
                end
                default: if (!w_spi_s && w_primed) r_state <= IDLE;
            endcase
        end
    end

    wbm_spi_fifo #(.WIDTH(BYTE_W), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
        .i_clk   (wb_clk_i),
        .i_rst_n (wb_rst_ni),
        .i_push  (w_push),
        .i_din   (handshake_data),
        .i_pop   (rx_ready),
        .o_dout  (rx_data),
        .o_valid (rx_valid),
        .o_full  (w_full),
        .o_level (rx_level)
    );
endmodule
